vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator that succeeds the fixed 640x480 timing block. It counts pixel clocks into horizontal and vertical positions and produces aligned, registered hcount/vcount, hsync, vsync, de and line/frame start strobes. Sync polarity is per-axis, counting can be stalled with a clock enable, and a new timing set can optionally be loaded at run time, taking effect only on a frame boundary. It sits between the pixel clock source and the pixel pipeline and video output encoder.

## Interface
- CW, 12: counter width; each axis total must be at most 2^CW.
- H_VISIBLE, 640; H_FRONT_PORCH, 16; H_SYNC_PULSE, 96; H_BACK_PORCH, 48: horizontal timing in pixels.
- V_VISIBLE, 480; V_FRONT_PORCH, 10; V_SYNC_PULSE, 2; V_BACK_PORCH, 33: vertical timing in lines.
- H_SYNC_POL, 0; V_SYNC_POL, 0: active level of each sync (0 = active-low).

Ports:
- clk_pix  in  1  pixel clock; the block's only clock.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; when low, all state and outputs hold.
- hcount  out  CW  horizontal position of the current output pixel.
- vcount  out  CW  vertical position of the current output pixel.
- hsync  out  1  horizontal sync at H_SYNC_POL.
- vsync  out  1  vertical sync at V_SYNC_POL.
- de  out  1  high in the visible area.
- line_start  out  1  high while hcount == 0.
- frame_start  out  1  high while hcount == 0 and vcount == 0.
- cfg_valid  in  1  (macro only) new timing offered.
- cfg_ready  out  1  (macro only) shadow register is free.
- cfg_timing  in  8*CW  (macro only) packed vga_timing_t.
- cfg_applied  out  1  (macro only) new timing is active from this pixel on.
- cfg_err  out  1  (macro only) one-cycle pulse: the accepted config was rejected.

## Operation
- The internal counters hc and vc start at 0. On each cycle with en high:
  - hc increments.
  - At hc == H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc == V_TOTAL-1 (on that same wrap), vc wraps to 0.
  - H_TOTAL and V_TOTAL are the sums of the four fields of their axis.
- All outputs are registered and are computed from the same hc/vc. They are therefore mutually coherent, one cycle behind the counter state.
- de = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- hsync is active for H_VISIBLE+H_FRONT_PORCH <= hc < H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE. vsync follows the same rule on vc with the V fields.
- Default timing: totals 800 x 525; hsync active for hcount 656..751; vsync active for vcount 490..491.
- With en low, the counters and every output, strobes included, hold their values. A strobe stays high if en drops while it is asserted.

Reset values (resetn low):
- hcount = 0, vcount = 0, de = 0.
- hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
- line_start = 0, frame_start = 0.
- cfg_applied = 0, cfg_err = 0, cfg_ready = 1.
- Shadow register is empty; active timing reverts to the parameters.

Reset asserted mid-frame forces all of the above immediately and asynchronously. The frame restarts from (0,0).

## Timing
- Latency: 1 en-cycle from counter state to outputs.
- The first en-high cycle after reset release loads outputs for (0,0): de = 1, line_start = 1, frame_start = 1.
- Strobes are one en-cycle wide.
- Frame period is H_TOTAL*V_TOTAL en-cycles (default 420000).

## Configuration
- Macro: VGA_TIMING_DYN_CFG_EN.
- Defined:
  - A cfg_valid && cfg_ready handshake loads the shadow register; cfg_ready then drops.
  - At the next frame wrap (hc == H_TOTAL-1, vc == V_TOTAL-1, en high), the shadow becomes the active timing and cfg_ready returns to 1.
  - cfg_applied pulses together with that frame_start.
  - Rejection: if any visible or sync field is 0, or either total exceeds 2^CW, the shadow is discarded at acceptance. cfg_err pulses the next cycle, cfg_ready stays 1, and the timing is unchanged.
  - A handshake on the same cycle as a frame wrap applies at the following wrap, not this one.
- Undefined: the cfg ports are absent, timing is parameter-only, and no shadow logic is built.

## Structure
- Package vga_timing_pkg holds:
  - typedef vga_timing_t: packed struct, eight CW-bit fields, in the order h_visible, h_fp, h_sync, h_bp, v_visible, v_fp, v_sync, v_bp.
  - Constant VGA_640X480_60 holding the default values.
  - Function timing_valid() implementing the rejection rule.
- Sub-module vga_axis_counter is natural and is instantiated once per axis:
  - Increments on inc; pulses wrap at total-1.
  - Provides registered vis and sync decode against the active fields.

## Test plan
- Defaults, en tied high, reset released: frame_start at the first output and again exactly 420000 cycles later; hsync low for exactly 96 cycles per line starting at hcount 656; de-high count per frame = 307200.
- Polarity: H_SYNC_POL = 1, V_SYNC_POL = 1 → during reset hsync = vsync = 0; hsync is high only for hcount 656..751.
- en toggling 1-of-3 cycles → output sequence identical to the en-high run with each value repeated; frame period = 1260000 clocks.
- Reset pulled low at hcount 300 / vcount 200 → outputs go to reset values immediately; first en cycle after release gives (0,0) with frame_start = 1.
- Dynamic config (macro defined), 800x600 set (40/128/88, 1/4/23) offered mid-frame:
  - cfg_ready drops.
  - The old frame completes at 800x525.
  - cfg_applied coincides with the next frame_start.
  - The next frame is 1056x628.
- Dynamic config with h_visible = 0 → cfg_err pulses once, cfg_ready stays 1, timing unchanged. A handshake exactly on the wrap cycle applies one frame later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: raster timing record, the 640x480@60 default set and the timing sanity rule
package vga_timing_pkg;
  localparam int VGA_CW = 12;
  typedef struct packed {
    logic [VGA_CW-1:0] h_visible;
    logic [VGA_CW-1:0] h_fp;
    logic [VGA_CW-1:0] h_sync;
    logic [VGA_CW-1:0] h_bp;
    logic [VGA_CW-1:0] v_visible;
    logic [VGA_CW-1:0] v_fp;
    logic [VGA_CW-1:0] v_sync;
    logic [VGA_CW-1:0] v_bp;
  } vga_timing_t;
  localparam vga_timing_t VGA_640X480_60 = '{
    h_visible: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_visible: 12'd480, v_fp: 12'd10, v_sync: 12'd2, v_bp: 12'd33
  };
  // A usable set needs non-empty visible and sync spans and totals that fit a cw-bit counter.
  function automatic logic timing_valid(input int unsigned hv, input int unsigned hf,
                                        input int unsigned hs, input int unsigned hb,
                                        input int unsigned vv, input int unsigned vf,
                                        input int unsigned vs, input int unsigned vb,
                                        input int unsigned cw);
    return hv != 0 && hs != 0 && vv != 0 && vs != 0 &&
           hv + hf + hs + hb <= (32'd1 << cw) && vv + vf + vs + vb <= (32'd1 << cw);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis position counter with registered position, visible, sync and zero decode
module vga_axis_counter #(
  parameter int CW = 12
) (
  input  logic          clk_pix,
  input  logic          resetn,
  input  logic          en,
  input  logic          inc,
  input  logic [CW-1:0] visible,
  input  logic [CW-1:0] fp,
  input  logic [CW-1:0] sync,
  input  logic [CW-1:0] bp,
  output logic          last,
  output logic [CW-1:0] pos,
  output logic          vis,
  output logic          sync_on,
  output logic          at_zero
);
  localparam int W = CW + 2;
  logic [CW-1:0] cnt;
  logic [W-1:0] ext, total, sync_lo, sync_hi;
  always_comb begin
    ext = W'(cnt);
    sync_lo = W'(visible) + W'(fp);
    sync_hi = sync_lo + W'(sync);
    total = sync_hi + W'(bp);
    last = ext == total - W'(1);
  end
  // Decode registers follow en, not inc, so the slow axis stays aligned with the fast one.
  always_ff @(posedge clk_pix or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      pos <= '0;
      vis <= 1'b0;
      sync_on <= 1'b0;
      at_zero <= 1'b0;
    end else begin
      if (inc) cnt <= last ? '0 : cnt + CW'(1);
      if (en) begin
        pos <= cnt;
        vis <= ext < W'(visible);
        sync_on <= ext >= sync_lo && ext < sync_hi;
        at_zero <= cnt == '0;
      end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator; VGA_TIMING_DYN_CFG_EN adds run-time timing reload at frame wrap
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW            = 12,
  parameter int H_VISIBLE     = int'(VGA_640X480_60.h_visible),
  parameter int H_FRONT_PORCH = int'(VGA_640X480_60.h_fp),
  parameter int H_SYNC_PULSE  = int'(VGA_640X480_60.h_sync),
  parameter int H_BACK_PORCH  = int'(VGA_640X480_60.h_bp),
  parameter int V_VISIBLE     = int'(VGA_640X480_60.v_visible),
  parameter int V_FRONT_PORCH = int'(VGA_640X480_60.v_fp),
  parameter int V_SYNC_PULSE  = int'(VGA_640X480_60.v_sync),
  parameter int V_BACK_PORCH  = int'(VGA_640X480_60.v_bp),
  parameter bit H_SYNC_POL    = 1'b0,
  parameter bit V_SYNC_POL    = 1'b0
) (
  input  logic          clk_pix,
  input  logic          resetn,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_DYN_CFG_EN
  ,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [8*CW-1:0] cfg_timing,
  output logic            cfg_applied,
  output logic            cfg_err
`endif
);
  localparam logic [8*CW-1:0] PARAM_TIMING = {
    CW'(H_VISIBLE), CW'(H_FRONT_PORCH), CW'(H_SYNC_PULSE), CW'(H_BACK_PORCH),
    CW'(V_VISIBLE), CW'(V_FRONT_PORCH), CW'(V_SYNC_PULSE), CW'(V_BACK_PORCH)
  };
  logic [8*CW-1:0] act;
  logic h_last, v_last, frame_wrap;
  logic h_vis, v_vis, h_sync_on, v_sync_on, h_zero, v_zero;
  assign frame_wrap = en && h_last && v_last;
  vga_axis_counter #(.CW(CW)) u_h (
    .clk_pix(clk_pix), .resetn(resetn), .en(en), .inc(en),
    .visible(act[7*CW +: CW]), .fp(act[6*CW +: CW]), .sync(act[5*CW +: CW]), .bp(act[4*CW +: CW]),
    .last(h_last), .pos(hcount), .vis(h_vis), .sync_on(h_sync_on), .at_zero(h_zero)
  );
  vga_axis_counter #(.CW(CW)) u_v (
    .clk_pix(clk_pix), .resetn(resetn), .en(en), .inc(en && h_last),
    .visible(act[3*CW +: CW]), .fp(act[2*CW +: CW]), .sync(act[CW +: CW]), .bp(act[0 +: CW]),
    .last(v_last), .pos(vcount), .vis(v_vis), .sync_on(v_sync_on), .at_zero(v_zero)
  );
  assign hsync = h_sync_on ? H_SYNC_POL : !H_SYNC_POL;
  assign vsync = v_sync_on ? V_SYNC_POL : !V_SYNC_POL;
  assign de = h_vis && v_vis;
  assign line_start = h_zero;
  assign frame_start = h_zero && v_zero;
`ifdef VGA_TIMING_DYN_CFG_EN
  logic [8*CW-1:0] shadow;
  logic full, pend, hs, ok;
  assign cfg_ready = !full;
  assign hs = cfg_valid && !full;
  assign ok = timing_valid(32'(cfg_timing[7*CW +: CW]), 32'(cfg_timing[6*CW +: CW]),
                           32'(cfg_timing[5*CW +: CW]), 32'(cfg_timing[4*CW +: CW]),
                           32'(cfg_timing[3*CW +: CW]), 32'(cfg_timing[2*CW +: CW]),
                           32'(cfg_timing[CW +: CW]), 32'(cfg_timing[0 +: CW]), CW);
  // A handshake needs an empty shadow and a swap needs a full one, so a wrap-cycle handshake waits a frame.
  always_ff @(posedge clk_pix or negedge resetn)
    if (!resetn) begin
      act <= PARAM_TIMING;
      shadow <= '0;
      full <= 1'b0;
      pend <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= hs && !ok;
      if (hs && ok) begin
        shadow <= cfg_timing;
        full <= 1'b1;
      end
      if (frame_wrap && full) begin
        act <= shadow;
        full <= 1'b0;
      end
      if (en) begin
        cfg_applied <= pend;
        pend <= frame_wrap && full;
      end
    end
`else
  assign act = PARAM_TIMING;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small-raster instance and a default-timing, positive-sync instance
module tb_vga_timing_gen;
  logic clk_pix = 1'b0, resetn = 1'b0, en = 1'b0;
  always #5 clk_pix = ~clk_pix;
  logic [7:0] hc0, vc0;
  logic hs0, vs0, de0, ls0, fs0;
  logic [11:0] hc1, vc1;
  logic hs1, vs1, de1, ls1, fs1;
  int passed = 0, total = 0;
`ifdef VGA_TIMING_DYN_CFG_EN
  logic cfg_valid = 1'b0, cfg_ready, cfg_applied, cfg_err;
  logic [63:0] cfg_timing = '0;
  logic r1, a1, e1;
`endif
  vga_timing_gen #(
    .CW(8), .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1)
  ) dut0 (
    .clk_pix(clk_pix), .resetn(resetn), .en(en), .hcount(hc0), .vcount(vc0),
    .hsync(hs0), .vsync(vs0), .de(de0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_DYN_CFG_EN
    , .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_timing(cfg_timing),
    .cfg_applied(cfg_applied), .cfg_err(cfg_err)
`endif
  );
  vga_timing_gen #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) dut1 (
    .clk_pix(clk_pix), .resetn(resetn), .en(en), .hcount(hc1), .vcount(vc1),
    .hsync(hs1), .vsync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_DYN_CFG_EN
    , .cfg_valid(1'b0), .cfg_ready(r1), .cfg_timing(96'd0), .cfg_applied(a1), .cfg_err(e1)
`endif
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask
  task automatic wait_frame(output int t);
    t = 0;
    do begin
      tick();
      t++;
    end while (!fs0 && t < 2000);
    check("frame_seen", fs0, 1);
  endtask
  initial begin
    int dec, hsl, vsl, lsc, fsc, herr, h1c, h1f, h1l, err, n, t;
    dec = 0; hsl = 0; vsl = 0; lsc = 0; fsc = 0; herr = 0; h1c = 0; h1f = -1; h1l = -1;
    repeat (3) tick();
    check("rst_hcount", hc0, 0);
    check("rst_vcount", vc0, 0);
    check("rst_de", de0, 0);
    check("rst_hsync", hs0, 1);
    check("rst_vsync", vs0, 1);
    check("rst_line_start", ls0, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_hsync_pos", hs1, 0);
    check("rst_vsync_pos", vs1, 0);
    resetn = 1'b1;
    en = 1'b1;
    tick();
    for (int i = 0; i <= 800; i++) begin
      if (i == 0) begin
        check("first_hcount", hc0, 0);
        check("first_vcount", vc0, 0);
        check("first_de", de0, 1);
        check("first_line_start", ls0, 1);
        check("first_frame_start", fs0, 1);
        check("first_frame_start_def", fs1, 1);
      end
      if (i < 120) begin
        dec += de0;
        hsl += !hs0;
        vsl += !vs0;
        lsc += ls0;
        fsc += fs0;
        if (!hs0 && (hc0 < 10 || hc0 > 12)) herr++;
      end
      if (i == 120) begin
        check("frame_period_fs", fs0, 1);
        check("frame_period_h", hc0, 0);
        check("frame_period_v", vc0, 0);
      end
      if (i < 800 && hs1) begin
        h1c++;
        if (h1f < 0) h1f = hc1;
        h1l = hc1;
      end
      if (i == 800) begin
        check("def_line2_h", hc1, 0);
        check("def_line2_v", vc1, 1);
        check("def_line2_ls", ls1, 1);
        check("def_line2_fs", fs1, 0);
      end
      if (i < 800) tick();
    end
    check("de_per_frame", dec, 32);
    check("hsync_low_cycles", hsl, 24);
    check("vsync_low_cycles", vsl, 30);
    check("line_starts", lsc, 8);
    check("frame_starts", fsc, 1);
    check("hsync_window", herr, 0);
    check("def_hsync_len", h1c, 96);
    check("def_hsync_first", h1f, 656);
    check("def_hsync_last", h1l, 751);
    for (t = 0; t < 200 && !(hc0 == 5 && vc0 == 3); t++) tick();
    check("mid_reach_h", hc0, 5);
    check("mid_de_before", de0, 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_hcount", hc0, 0);
    check("mid_rst_vcount", vc0, 0);
    check("mid_rst_de", de0, 0);
    check("mid_rst_hsync", hs0, 1);
    check("mid_rst_ls", ls0, 0);
    en = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    err = 0;
    for (int c = 0; c <= 360; c++) begin
      en = (c % 3 == 0);
      tick();
      n = c / 3;
      if (hc0 != n % 15 || vc0 != (n / 15) % 8 || fs0 != (n % 120 == 0)) err++;
      if (c == 0) check("release_fs", fs0, 1);
      if (c == 2) check("en_strobe_hold", fs0, 1);
      if (c == 359) check("en_fs_low", fs0, 0);
      if (c == 360) check("en_frame_period", fs0, 1);
    end
    check("en_seq_errors", err, 0);
    en = 1'b1;
`ifdef VGA_TIMING_DYN_CFG_EN
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    repeat (20) tick();
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_timing = {8'd4, 8'd1, 8'd2, 8'd1, 8'd3, 8'd1, 8'd1, 8'd1};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("cfg_ready_drop", cfg_ready, 0);
    wait_frame(t);
    check("cfg_old_frame", t, 99);
    check("cfg_applied_pulse", cfg_applied, 1);
    check("cfg_ready_back", cfg_ready, 1);
    wait_frame(t);
    check("cfg_new_frame", t, 48);
    check("cfg_applied_once", cfg_applied, 0);
    cfg_timing = {8'd0, 8'd1, 8'd2, 8'd1, 8'd3, 8'd1, 8'd1, 8'd1};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_ready", cfg_ready, 1);
    tick();
    check("cfg_err_clear", cfg_err, 0);
    wait_frame(t);
    wait_frame(t);
    check("cfg_err_unchanged", t, 48);
    for (t = 0; t < 200 && !(hc0 == 6 && vc0 == 5); t++) tick();
    check("wrap_reach_v", vc0, 5);
    cfg_timing = {8'd8, 8'd2, 8'd3, 8'd2, 8'd4, 8'd1, 8'd2, 8'd1};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    check("wrap_fs", fs0, 1);
    check("wrap_not_applied", cfg_applied, 0);
    check("wrap_pending", cfg_ready, 0);
    wait_frame(t);
    check("wrap_old_frame", t, 48);
    check("wrap_applied", cfg_applied, 1);
    wait_frame(t);
    check("wrap_new_frame", t, 120);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
